// File: rtl/aes_inv_key_expansion_if.sv
// Handshake bundle for the AES-128 inverse key schedule.
// ready_in exists only when AES_INVKEY_STALL_EN is defined.
interface aes_inv_key_expansion_if;
  logic        start_in;
  logic [31:0] key0_in;
  logic [31:0] key1_in;
  logic [31:0] key2_in;
  logic [31:0] key3_in;
`ifdef AES_INVKEY_STALL_EN
  logic        ready_in;
`endif
  logic [31:0] key0_out;
  logic [31:0] key1_out;
  logic [31:0] key2_out;
  logic [31:0] key3_out;
  logic [3:0]  round_out;
  logic        valid_out;
  logic        last_out;
  logic        busy_out;

  modport master (
`ifdef AES_INVKEY_STALL_EN
    output ready_in,
`endif
    output start_in,
    output key0_in, key1_in,
    output key2_in, key3_in,
    input  key0_out, key1_out,
    input  key2_out, key3_out,
    input  round_out, valid_out,
    input  last_out, busy_out
  );

  modport slave (
`ifdef AES_INVKEY_STALL_EN
    input  ready_in,
`endif
    input  start_in,
    input  key0_in, key1_in,
    input  key2_in, key3_in,
    output key0_out, key1_out,
    output key2_out, key3_out,
    output round_out, valid_out,
    output last_out, busy_out
  );
endinterface

// File: rtl/aes_inv_key_expansion.sv
// AES-128 inverse key schedule: round keys 10..0, one per accepted cycle.
// Define AES_INVKEY_STALL_EN to add ready_in backpressure.
module aes_inv_key_expansion (
  input logic CLK,
  input logic RST,
  aes_inv_key_expansion_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [127:0] SB [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t      state;
  logic [3:0]  round_r;
  logic [31:0] w0_r, w1_r, w2_r, w3_r;
  logic [31:0] n0, n1, n2, n3, g;
  logic        accept, run, in_rng;
  logic        step, hold;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    logic [6:0]   lo;
    row = SB[b[7:4]];
    lo  = 7'd120 - {b[3:0], 3'b000};
    return row[lo +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    unique case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

`ifdef AES_INVKEY_STALL_EN
  assign accept = bus.ready_in;
`else
  assign accept = 1'b1;
`endif

  // g() sees the freshly derived w3', and Rcon uses the current round
  assign n3 = w3_r ^ w2_r;
  assign n2 = w2_r ^ w1_r;
  assign n1 = w1_r ^ w0_r;
  assign g  = sub_word({n3[23:0], n3[31:24]})
            ^ {rcon(round_r), 24'h0};
  assign n0 = w0_r ^ g;

  assign run    = (state == RUN);
  assign in_rng = (round_r <= 4'd10);
  assign step   = run & in_rng & accept & (round_r != 4'd0);
  assign hold   = run & in_rng & ~accept;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      round_r <= 4'd0;
      w0_r    <= '0;
      w1_r    <= '0;
      w2_r    <= '0;
      w3_r    <= '0;
    end else begin
      unique case (1'b1)
        !run: begin
          if (bus.start_in) begin
            state   <= RUN;
            round_r <= 4'd10;
            w0_r    <= bus.key0_in;
            w1_r    <= bus.key1_in;
            w2_r    <= bus.key2_in;
            w3_r    <= bus.key3_in;
          end else begin
            round_r <= 4'd0;
            w0_r    <= '0;
            w1_r    <= '0;
            w2_r    <= '0;
            w3_r    <= '0;
          end
        end
        step: begin
          round_r <= round_r - 4'd1;
          w0_r    <= n0;
          w1_r    <= n1;
          w2_r    <= n2;
          w3_r    <= n3;
        end
        hold: begin
          state <= RUN;
        end
        default: begin
          state   <= IDLE;
          round_r <= 4'd0;
          w0_r    <= '0;
          w1_r    <= '0;
          w2_r    <= '0;
          w3_r    <= '0;
        end
      endcase
    end
  end

  assign bus.key0_out  = run ? w0_r : '0;
  assign bus.key1_out  = run ? w1_r : '0;
  assign bus.key2_out  = run ? w2_r : '0;
  assign bus.key3_out  = run ? w3_r : '0;
  assign bus.round_out = run ? round_r : 4'd0;
  assign bus.valid_out = run;
  assign bus.last_out  = run & (round_r == 4'd0);
  assign bus.busy_out  = run;
endmodule
